// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ysyx_22041211_ifu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] IFU_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_if.sv
// SRAM-like instruction memory port: one request channel, one response pulse.
interface ysyx_22041211_ifu_if;
    import ysyx_22041211_ifu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/ysyx_22041211_ifu_reg.sv
// Generic enable register with synchronous active-high reset.
module ysyx_22041211_Reg #(
    parameter int unsigned        WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst)        q_o <= RESET_VAL;
        else if (wen_i) q_o <= d_i;
    end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: owns the PC, runs one fetch at a time, hands {inst, pc}
// to the decoder and squashes wrong-path fetches on redirect.
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = IFU_NOP_INST
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22041211_ifu_if.master        imem,
    input  logic                       redirect_valid_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [XLEN-1:0]            inst_o,
    output logic [XLEN-1:0]            pc_o,
    output logic                       fetch_err_o
);

    ifu_state_e      state_q;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, pco_q;
    logic            err_q;
    logic            pc_we, req_hs, inst_hs, redir_mis;

    assign imem.req_valid = (state_q == IFU_REQ);
    assign imem.req_addr  = pc_q;
    assign inst_valid_o   = (state_q == IFU_HOLD);
    assign inst_o         = inst_q;
    assign pc_o           = pco_q;
    assign fetch_err_o    = err_q;

    assign req_hs    = imem.req_valid & imem.req_ready;
    assign inst_hs   = inst_valid_o & inst_ready_i;
    assign redir_mis = misaligned(redirect_pc_i);

    assign pc_we = redirect_valid_i | inst_hs;
    assign pc_d  = redirect_valid_i ? redirect_pc_i : pc_q + 32'd4;

    ysyx_22041211_Reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .rst   (rst),
        .wen_i (pc_we),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // A stale response clears drop in whatever state it lands; a redirect arms it
    // whenever a request on the old pc is (or is about to be) outstanding.
    assign drop_d = (redirect_valid_i & ((state_q == IFU_REQ  & req_hs) |
                                         (state_q == IFU_WAIT & ~imem.rsp_valid)))
                  | (drop_q & ~imem.rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFU_REQ;
            drop_q  <= 1'b0;
            inst_q  <= NOP_INST;
            pco_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (redirect_valid_i) begin
                if (redir_mis) begin
                    state_q <= IFU_HOLD;
                    inst_q  <= NOP_INST;
                    pco_q   <= redirect_pc_i;
                    err_q   <= 1'b1;
                end else begin
                    unique case (state_q)
                        IFU_REQ:  state_q <= req_hs ? IFU_WAIT : IFU_REQ;
                        IFU_WAIT: state_q <= imem.rsp_valid ? IFU_REQ : IFU_WAIT;
                        default:  state_q <= IFU_REQ;
                    endcase
                end
            end else begin
                unique case (state_q)
                    IFU_REQ: if (req_hs) state_q <= IFU_WAIT;
                    IFU_WAIT: begin
                        if (imem.rsp_valid) begin
                            if (drop_q) begin
                                state_q <= IFU_REQ;
                            end else begin
                                state_q <= IFU_HOLD;
                                inst_q  <= imem.rsp_err ? NOP_INST : imem.rsp_data;
                                pco_q   <= pc_q;
                                err_q   <= imem.rsp_err;
                            end
                        end
                    end
                    IFU_HOLD: if (inst_ready_i) state_q <= IFU_REQ;
                    default:  state_q <= IFU_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized run checked
// against an architectural-PC model of the fetch stream.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o, pc_o;
    logic        fetch_err_o;

    always #5 clk = ~clk;

    ysyx_22041211_ifu_if imem();

    ysyx_22041211_ifu #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imem),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .fetch_err_o      (fetch_err_o)
    );

    int errors = 0;
    int checks = 0;

    // stimulus knobs
    logic        rdy = 1'b0, redir = 1'b0;
    logic [31:0] rpc = '0;
    int          mlat = 1;
    bit          mrand = 0, err_rand = 0, use_fix = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // memory model state
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] maddr = '0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (use_fix) return 32'h0000_0093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic merr(input logic [31:0] a);
        return (a == err_addr) || (err_rand && a[6:2] == 5'd7);
    endfunction

    // One clock: drive inputs for the current cycle, advance to just after the edge.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        imem.rsp_valid = busy && cnt == 0;
        imem.rsp_data  = imem.rsp_valid ? mdata(maddr) : $urandom;
        imem.rsp_err   = imem.rsp_valid ? merr(maddr) : 1'b0;
        imem.req_ready = !busy && (!mrand || $urandom_range(0, 3) != 0);
        inst_ready_i     = rdy;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        hs = imem.req_valid && imem.req_ready;
        a  = imem.req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            busy = 0;
        end else begin
            if (busy) begin
                if (cnt == 0) busy = 0;
                else cnt--;
            end
            if (hs) begin
                busy = 1; cnt = mlat - 1; maddr = a;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b0; redir = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic run_until_valid(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (inst_valid_o) begin ok = 1; return; end
            step();
        end
        ok = inst_valid_o;
    endtask

    task automatic run_until_req(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (imem.req_valid) begin ok = 1; return; end
            step();
        end
        ok = imem.req_valid;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc_o got=%h exp=0", pc_o); end
        checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", fetch_err_o); end
        checks++; if (imem.req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got=%b exp=1", imem.req_valid); end
        checks++; if (imem.req_addr !== RPC) begin errors++; $display("FAIL reset_req_addr got=%h exp=%h", imem.req_addr, RPC); end
    endtask

    task automatic test_stream();
        bit          expv;
        logic [31:0] ep;
        do_reset();
        use_fix = 1; mlat = 1; rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            expv = (c % 3 == 2);
            ep   = RPC + 32'(4 * (c / 3));
            checks++; if (inst_valid_o !== expv) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, inst_valid_o, expv); end
            if (expv) begin
                checks++; if (pc_o !== ep || inst_o !== 32'h0000_0093 || fetch_err_o !== 1'b0) begin
                    errors++; $display("FAIL stream_data c=%0d got pc=%h inst=%h err=%b exp pc=%h inst=00000093 err=0", c, pc_o, inst_o, fetch_err_o, ep);
                end
            end
            step();
        end
        use_fix = 0; rdy = 1'b0;
    endtask

    task automatic test_stall();
        bit          ok;
        logic [31:0] hi, hp;
        do_reset();
        mlat = 1; rdy = 1'b0;
        run_until_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=no_valid exp=valid"); end
        hi = inst_o; hp = pc_o;
        checks++; if (hp !== RPC || hi !== mdata(RPC)) begin errors++; $display("FAIL stall_first got pc=%h inst=%h exp pc=%h inst=%h", hp, hi, RPC, mdata(RPC)); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_valid_o !== 1'b1 || inst_o !== hi || pc_o !== hp || imem.req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold i=%0d got v=%b inst=%h pc=%h req=%b exp v=1 inst=%h pc=%h req=0", i, inst_valid_o, inst_o, pc_o, imem.req_valid, hi, hp);
            end
            step();
        end
        rdy = 1'b1; step(); rdy = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== hp + 32'd4) begin
            errors++; $display("FAIL stall_release got v=%b req=%b addr=%h exp v=0 req=1 addr=%h", inst_valid_o, imem.req_valid, imem.req_addr, hp + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        mlat = 1; rdy = 1'b1;
        run_until_valid(10, ok);
        checks++; if (!ok || pc_o !== RPC) begin errors++; $display("FAIL rw_first got ok=%b pc=%h exp ok=1 pc=%h", ok, pc_o, RPC); end
        step();
        mlat = 3;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8000_0004) begin
            errors++; $display("FAIL rw_req got req=%b addr=%h exp req=1 addr=80000004", imem.req_valid, imem.req_addr);
        end
        step();
        redir = 1'b1; rpc = 32'h8000_0100; step(); redir = 1'b0;
        run_until_req(10, ok);
        checks++; if (!ok || imem.req_addr !== 32'h8000_0100 || inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL rw_retarget got ok=%b addr=%h v=%b exp ok=1 addr=80000100 v=0", ok, imem.req_addr, inst_valid_o);
        end
        mlat = 1;
        run_until_valid(10, ok);
        checks++; if (!ok || pc_o !== 32'h8000_0100 || inst_o !== mdata(32'h8000_0100)) begin
            errors++; $display("FAIL rw_deliver got pc=%h inst=%h exp pc=80000100 inst=%h", pc_o, inst_o, mdata(32'h8000_0100));
        end
        rdy = 1'b0;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        do_reset();
        mlat = 1; rdy = 1'b1;
        run_until_valid(10, ok);
        redir = 1'b1; rpc = 32'h8000_0200; step(); redir = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8000_0200) begin
            errors++; $display("FAIL rh_kill got v=%b req=%b addr=%h exp v=0 req=1 addr=80000200", inst_valid_o, imem.req_valid, imem.req_addr);
        end
        run_until_valid(10, ok);
        checks++; if (!ok || pc_o !== 32'h8000_0200 || inst_o !== mdata(32'h8000_0200) || fetch_err_o !== 1'b0) begin
            errors++; $display("FAIL rh_deliver got pc=%h inst=%h err=%b exp pc=80000200 inst=%h err=0", pc_o, inst_o, fetch_err_o, mdata(32'h8000_0200));
        end
        rdy = 1'b0;
    endtask

    task automatic test_fault();
        bit ok;
        do_reset();
        mlat = 1; rdy = 1'b0; err_addr = RPC;
        run_until_valid(10, ok);
        checks++; if (!ok || inst_o !== NOP || fetch_err_o !== 1'b1 || pc_o !== RPC) begin
            errors++; $display("FAIL fault_rsp got inst=%h err=%b pc=%h exp inst=%h err=1 pc=%h", inst_o, fetch_err_o, pc_o, NOP, RPC);
        end
        err_addr = 32'hFFFF_FFFF;
        rdy = 1'b1; step(); rdy = 1'b0;
        run_until_valid(10, ok);
        checks++; if (!ok || fetch_err_o !== 1'b0 || pc_o !== 32'h8000_0004) begin
            errors++; $display("FAIL fault_clear got err=%b pc=%h exp err=0 pc=80000004", fetch_err_o, pc_o);
        end
        redir = 1'b1; rpc = 32'h8000_0102; step(); redir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8000_0102 || fetch_err_o !== 1'b1 || inst_o !== NOP || imem.req_valid !== 1'b0) begin
                errors++; $display("FAIL fault_misalign i=%0d got v=%b pc=%h err=%b inst=%h req=%b exp v=1 pc=80000102 err=1 inst=%h req=0", i, inst_valid_o, pc_o, fetch_err_o, inst_o, imem.req_valid, NOP);
            end
            step();
        end
        rdy = 1'b1; step(); rdy = 1'b0;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8000_0106) begin
            errors++; $display("FAIL fault_after got req=%b addr=%h exp req=1 addr=80000106", imem.req_valid, imem.req_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        do_reset();
        mlat = 1; rdy = 1'b0;
        run_until_valid(10, ok);
        redir = 1'b1; rpc = 32'hFFFF_FFFC; step(); redir = 1'b0;
        run_until_valid(10, ok);
        checks++; if (!ok || pc_o !== 32'hFFFF_FFFC || inst_o !== mdata(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_deliver got pc=%h inst=%h exp pc=fffffffc inst=%h", pc_o, inst_o, mdata(32'hFFFF_FFFC));
        end
        rdy = 1'b1; step(); rdy = 1'b0;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got req=%b addr=%h exp req=1 addr=00000000", imem.req_valid, imem.req_addr);
        end
        mlat = 3; step();
        checks++; if (imem.req_valid !== 1'b0) begin errors++; $display("FAIL midwait_state got req=%b exp 0", imem.req_valid); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== RPC || inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL midwait_reset got req=%b addr=%h v=%b exp req=1 addr=%h v=0", imem.req_valid, imem.req_addr, inst_valid_o, RPC);
        end
        mlat = 1;
        run_until_valid(10, ok);
        checks++; if (!ok || pc_o !== RPC) begin errors++; $display("FAIL midwait_resume got pc=%h exp %h", pc_o, RPC); end
    endtask

    task automatic test_random();
        logic [31:0] mpc, exp_inst;
        bit          mis, keep, exp_err, v;
        int          delivered;
        do_reset();
        mrand = 1; err_rand = 1;
        mpc = RPC; mis = 0; keep = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy   = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 15) == 0);
            rpc   = RPC | (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            mlat  = $urandom_range(1, 3);
            v = inst_valid_o;
            if (v) begin
                exp_err  = mis || merr(mpc);
                exp_inst = exp_err ? NOP : mdata(mpc);
                checks++; if (pc_o !== mpc || inst_o !== exp_inst || fetch_err_o !== exp_err) begin
                    errors++; $display("FAIL rand_inst c=%0d got pc=%h inst=%h err=%b exp pc=%h inst=%h err=%b", c, pc_o, inst_o, fetch_err_o, mpc, exp_inst, exp_err);
                end
            end
            if (imem.req_valid) begin
                checks++; if (imem.req_addr !== mpc) begin errors++; $display("FAIL rand_req c=%0d got addr=%h exp %h", c, imem.req_addr, mpc); end
            end
            if (keep) begin
                checks++; if (!v) begin errors++; $display("FAIL rand_valid_drop c=%0d got v=0 exp v=1", c); end
            end
            keep = v && !rdy && !redir;
            if (v && rdy && !redir) delivered++;
            step();
            if (redir) begin
                mpc = rpc; mis = (rpc[1:0] != 2'b00);
            end else if (v && rdy) begin
                mpc = mpc + 32'd4; mis = 0;
            end
        end
        redir = 1'b0; rdy = 1'b0; mrand = 0; err_rand = 0;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rand_progress got=%0d exp>=100", delivered); end
    endtask

    initial begin
        rst = 1'b1;
        imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0; imem.rsp_err = 1'b0;
        inst_ready_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_fault();
        test_wrap_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
